// File: rtl/traffic_light_xing_if.sv
// Control inputs and lamp/display outputs of the two-approach crossing controller.
// Handshake: none; all fields are levels sampled on clk (ped_req may be a pulse of any length).
interface traffic_light_xing_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             ped_req;
  logic             night_mode;
  logic             ns_red;
  logic             ns_yellow;
  logic             ns_green;
  logic             ew_red;
  logic             ew_yellow;
  logic             ew_green;
  logic             walk;
  logic [CNT_W-1:0] countdown;
  logic [6:0]       seg;

  modport slave (
    input  start, ped_req, night_mode,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output walk, countdown, seg
  );

  modport master (
    output start, ped_req, night_mode,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  walk, countdown, seg
  );
endinterface

// File: rtl/traffic_light_xing.sv
// NS/EW intersection controller with 1 s tick, latched pedestrian walk, night flashing mode
// and a per-phase seconds countdown on one 7-segment digit.
module traffic_light_xing #(
  parameter int TICK_DIV = 100000000,
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 5,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  traffic_light_xing_if.slave   xing,
  output logic [3:0]            state_o
);

  localparam int DIV_W = $clog2(TICK_DIV);

  typedef enum logic [3:0] {
    IDLE, NS_GREEN, NS_YELLOW, ALLRED1, EW_GREEN, EW_YELLOW, ALLRED2, WALK, NIGHT
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               ped_q, ped_d;
  logic               flash_q, flash_d;
  logic               tick;
  logic [CNT_W-1:0]   cnt_rem;

  function automatic logic [CNT_W-1:0] dur_of(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   dur_of = CNT_W'(GREEN_S);
      NS_YELLOW, EW_YELLOW: dur_of = CNT_W'(YELLOW_S);
      ALLRED1, ALLRED2:     dur_of = CNT_W'(ALLRED_S);
      WALK:                 dur_of = CNT_W'(WALK_S);
      default:              dur_of = '0;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  // Divider is held at zero in IDLE so the first second after start is full length.
  assign tick = (state_q != IDLE) && (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (state_q == IDLE || tick) div_d = '0;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flash_d = flash_q;
    unique case (state_q)
      IDLE: if (xing.start) state_d = NS_GREEN;
      NIGHT: begin
        if (tick) begin
          if (!xing.night_mode) state_d = ALLRED2;
          else                  flash_d = ~flash_q;
        end
      end
      default: begin
        if (tick) begin
          if (timer_q == CNT_W'(1)) begin
            unique case (state_q)
              NS_GREEN:  state_d = NS_YELLOW;
              NS_YELLOW: state_d = ALLRED1;
              ALLRED1:   state_d = xing.night_mode ? NIGHT : EW_GREEN;
              EW_GREEN:  state_d = EW_YELLOW;
              EW_YELLOW: state_d = ALLRED2;
              ALLRED2:   state_d = xing.night_mode ? NIGHT : (ped_q ? WALK : NS_GREEN);
              default:   state_d = NS_GREEN;
            endcase
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
      end
    endcase
    // Every phase change loads the new phase's duration in the same cycle.
    if (state_d != state_q) begin
      timer_d = dur_of(state_d);
      if (state_d == NIGHT) flash_d = 1'b1;
    end
  end

  // A request in the WALK-entry cycle re-arms the latch for one more walk.
  assign ped_d = (ped_q && !(state_d == WALK && state_q != WALK)) || xing.ped_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      timer_q <= '0;
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
    end
  end

  always_comb begin
    xing.ns_red    = 1'b1;
    xing.ns_yellow = 1'b0;
    xing.ns_green  = 1'b0;
    xing.ew_red    = 1'b1;
    xing.ew_yellow = 1'b0;
    xing.ew_green  = 1'b0;
    xing.walk      = 1'b0;
    unique case (state_q)
      NS_GREEN:  begin xing.ns_red = 1'b0; xing.ns_green  = 1'b1; end
      NS_YELLOW: begin xing.ns_red = 1'b0; xing.ns_yellow = 1'b1; end
      EW_GREEN:  begin xing.ew_red = 1'b0; xing.ew_green  = 1'b1; end
      EW_YELLOW: begin xing.ew_red = 1'b0; xing.ew_yellow = 1'b1; end
      WALK:      xing.walk = 1'b1;
      NIGHT: begin
        xing.ns_red    = 1'b0;
        xing.ew_red    = 1'b0;
        xing.ns_yellow = flash_q;
        xing.ew_yellow = flash_q;
      end
      default: ;
    endcase
  end

  assign xing.countdown = (state_q == IDLE || state_q == NIGHT) ? '0 : timer_q;
  assign cnt_rem        = xing.countdown % CNT_W'(10);
  assign xing.seg       = seg_of(4'(cnt_rem));
  assign state_o        = state_q;

endmodule

// File: tb/tb_traffic_light_xing.sv
// Bench for traffic_light_xing: vector table, directed corner sequences and a random run
// checked against a cycles-remaining phase model.
module tb_traffic_light_xing;
  localparam int TD = 4, G_S = 3, Y_S = 2, AR_S = 1, W_S = 2, CW = 4;

  localparam int P_IDLE = 0, P_NSG = 1, P_NSY = 2, P_AR1 = 3, P_EWG = 4, P_EWY = 5,
                 P_AR2 = 6, P_WALK = 7, P_NIGHT = 8;

  localparam logic [6:0] L_RED = 7'b1001000, L_NSG = 7'b0011000, L_NSY = 7'b0101000,
                         L_EWG = 7'b1000010, L_EWY = 7'b1000100, L_WALK = 7'b1001001;
  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011, S3 = 7'b1001111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dbg_state;
  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  traffic_light_xing_if #(.CNT_W(CW)) xif ();

  traffic_light_xing #(
    .TICK_DIV(TD), .GREEN_S(G_S), .YELLOW_S(Y_S), .ALLRED_S(AR_S), .WALK_S(W_S), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .xing(xif), .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  logic [6:0] act_lamps;
  assign act_lamps = {xif.ns_red, xif.ns_yellow, xif.ns_green,
                      xif.ew_red, xif.ew_yellow, xif.ew_green, xif.walk};

  int total = 0, bad = 0;
  int walk_cnt, saw_night, saw_nsg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus cycles left in it; seconds shown = ceil(cycles / TD).
  int m_ph = P_IDLE, m_left = 0;
  bit m_ped = 0, m_flash = 0;

  function automatic int dur_s(input int ph);
    case (ph)
      P_NSG, P_EWG: return G_S;
      P_NSY, P_EWY: return Y_S;
      P_AR1, P_AR2: return AR_S;
      P_WALK:       return W_S;
      default:      return 1;
    endcase
  endfunction

  task automatic m_enter(input int ph);
    m_ph = ph;
    m_left = dur_s(ph) * TD;
    if (ph == P_NIGHT) m_flash = 1;
    if (ph == P_WALK) m_ped = 0;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit pr, input bit nm);
    bit old_ped = m_ped;
    if (rst) begin
      m_ph = P_IDLE; m_left = 0; m_ped = 0; m_flash = 0;
      return;
    end
    if (m_ph == P_IDLE) begin
      if (st) m_enter(P_NSG);
    end else if (m_left > 1) begin
      m_left--;
    end else if (m_ph == P_NIGHT) begin
      if (!nm) m_enter(P_AR2);
      else begin m_flash = !m_flash; m_left = TD; end
    end else begin
      case (m_ph)
        P_NSG: m_enter(P_NSY);
        P_NSY: m_enter(P_AR1);
        P_AR1: m_enter(nm ? P_NIGHT : P_EWG);
        P_EWG: m_enter(P_EWY);
        P_EWY: m_enter(P_AR2);
        P_AR2: m_enter(nm ? P_NIGHT : (old_ped ? P_WALK : P_NSG));
        default: m_enter(P_NSG);
      endcase
    end
    if (pr) m_ped = 1;
  endtask

  function automatic logic [6:0] m_lamps();
    case (m_ph)
      P_NSG:   return L_NSG;
      P_NSY:   return L_NSY;
      P_EWG:   return L_EWG;
      P_EWY:   return L_EWY;
      P_WALK:  return L_WALK;
      P_NIGHT: return {1'b0, m_flash, 2'b00, m_flash, 2'b00};
      default: return L_RED;
    endcase
  endfunction

  function automatic int m_cd();
    if (m_ph == P_IDLE || m_ph == P_NIGHT) return 0;
    return (m_left + TD - 1) / TD;
  endfunction

  task automatic step(input bit rst, input bit st, input bit pr, input bit nm);
    reset = rst; xif.start = st; xif.ped_req = pr; xif.night_mode = nm;
    @(posedge clk);
    model_step(rst, st, pr, nm);
    #1;
    chk("lamps", 32'(act_lamps), 32'(m_lamps()));
    chk("countdown", 32'(xif.countdown), 32'(m_cd()));
    chk("seg", 32'(xif.seg), 32'(seg_tbl[m_cd() % 10]));
    chk("walk_needs_reds", 32'(xif.walk && !(xif.ns_red && xif.ew_red)), 32'd0);
    chk("one_lamp_per_appr", 32'((xif.ns_green && xif.ns_yellow) || (xif.ew_green && xif.ew_yellow)), 32'd0);
    if (xif.walk) walk_cnt++;
    if (xif.ns_yellow && xif.ew_yellow && !xif.ns_red) saw_night++;
    if (xif.ns_green) saw_nsg++;
  endtask

  task automatic run(input int n, input bit pr, input bit nm);
    for (int i = 0; i < n; i++) step(0, 0, pr, nm);
  endtask

  task automatic restart();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    walk_cnt = 0; saw_night = 0; saw_nsg = 0;
  endtask

  typedef struct {
    bit rst, st, pr, nm;
    int n;
    logic [6:0] lamps;
    logic [3:0] cd;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit rst, input bit st, input int n,
                              input logic [6:0] lamps, input logic [3:0] cd, input logic [6:0] seg);
    vec_t v;
    v.rst = rst; v.st = st; v.pr = 0; v.nm = 0; v.n = n; v.lamps = lamps; v.cd = cd; v.seg = seg;
    vecs.push_back(v);
  endfunction

  initial begin
    bit nm_r = 0;
    reset = 1; xif.start = 0; xif.ped_req = 0; xif.night_mode = 0;

    // Full normal cycle: reset, idle, start, every phase, NS_GREEN again 49 cycles after start.
    add(1, 0, 1, L_RED, 0, S0);  add(0, 0, 3, L_RED, 0, S0);
    add(0, 1, 1, L_NSG, 3, S3);  add(0, 0, 3, L_NSG, 3, S3);
    add(0, 0, 4, L_NSG, 2, S2);  add(0, 0, 4, L_NSG, 1, S1);
    add(0, 0, 4, L_NSY, 2, S2);  add(0, 0, 4, L_NSY, 1, S1);
    add(0, 0, 4, L_RED, 1, S1);
    add(0, 0, 4, L_EWG, 3, S3);  add(0, 0, 4, L_EWG, 2, S2);  add(0, 0, 4, L_EWG, 1, S1);
    add(0, 0, 4, L_EWY, 2, S2);  add(0, 0, 4, L_EWY, 1, S1);
    add(0, 0, 4, L_RED, 1, S1);  add(0, 0, 1, L_NSG, 3, S3);
    foreach (vecs[k]) begin
      for (int c = 0; c < vecs[k].n; c++) begin
        step(vecs[k].rst, vecs[k].st, vecs[k].pr, vecs[k].nm);
        chk("vec_lamps", 32'(act_lamps), 32'(vecs[k].lamps));
        chk("vec_cd", 32'(xif.countdown), 32'(vecs[k].cd));
        chk("vec_seg", 32'(xif.seg), 32'(vecs[k].seg));
      end
    end

    // Pedestrian pulse during EW_GREEN: exactly one 8-cycle walk.
    restart(); run(25, 0, 0); step(0, 0, 1, 0); run(80, 0, 0);
    chk("ped_one_walk", 32'(walk_cnt), 32'd8);

    // Night raised in NS_GREEN, entered at ALLRED1 expiry, exit via ALLRED2 to NS_GREEN.
    restart(); run(2, 0, 0); run(40, 0, 1);
    chk("night_entered", 32'(saw_night > 0), 32'd1);
    saw_nsg = 0; run(12, 0, 0);
    chk("night_exit_nsg", 32'(saw_nsg > 0), 32'd1);

    // Pedestrian request during NIGHT served right after leaving night.
    restart(); run(30, 0, 1); step(0, 0, 1, 1); run(6, 0, 1); run(30, 0, 0);
    chk("night_ped_walk", 32'(walk_cnt), 32'd8);

    // Reset mid EW_YELLOW, then start held low keeps IDLE.
    restart(); run(38, 0, 0);
    chk("pre_rst_ewy", 32'(xif.ew_yellow), 32'd1);
    step(1, 0, 0, 0);
    chk("rst_lamps", 32'(act_lamps), 32'(L_RED));
    chk("rst_cd", 32'(xif.countdown), 32'd0);
    chk("rst_seg", 32'(xif.seg), 32'(S0));
    saw_nsg = 0; run(50, 0, 0);
    chk("idle_stays", 32'(saw_nsg), 32'd0);
    chk("idle_lamps", 32'(act_lamps), 32'(L_RED));

    // ped_req held across WALK entry: a second walk follows at the next ALLRED2.
    restart(); run(30, 0, 0); run(23, 1, 0); run(100, 0, 0);
    chk("ped_held_two_walks", 32'(walk_cnt), 32'd16);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) nm_r = !nm_r;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0, nm_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
